// File: rtl/fixed_ceil.sv
// ---------------------------------------------------------------------------
// fixed_ceil
//
// Registered ceiling for a signed two's-complement Q(WI.WF) operand. The
// operand is rounded toward +infinity to the nearest integer. The result
// comes back in the same Q(WI.WF) format, one clock after the operand is
// sampled.
//
// Parameters
//   WI  integer bits including the sign bit (>= 2)
//   WF  fractional bits (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears all outputs
//   in_valid   A is sampled on the clk edge while high
//   A          signed operand, Q(WI.WF)
//   out_valid  high for the cycle after a sampled operand
//   ceilout    ceil(A) in Q(WI.WF); saturates to the most positive code
//   oflag      ceil(A) exceeded the most positive representable value
//
// ceilout and oflag keep their previous values while in_valid is low.
// ---------------------------------------------------------------------------
module fixed_ceil #(
  parameter int WI = 3,
  parameter int WF = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WI+WF-1:0] A,
  output logic             out_valid,
  output logic [WI+WF-1:0] ceilout,
  output logic             oflag
);

  localparam int W = WI + WF;

  // Most positive code in Q(WI.WF): a zero sign bit followed by all ones.
  localparam logic [W-1:0] MAX_CODE = {1'b0, {(W-1){1'b1}}};

  logic [WI-1:0] int_field_s;
  logic          frac_nz_s;
  logic [WI:0]   inc_s;
  logic          ovf_s;
  logic [W-1:0]  ceil_s;

  logic          out_valid_r;
  logic [W-1:0]  ceil_r;
  logic          oflag_r;

  // Split the operand and form the sign-extended integer field plus one.
  always_comb begin
    int_field_s = A[W-1:WF];
    frac_nz_s   = |A[WF-1:0];
    // The floor of a two's-complement value is its integer field, so adding
    // one whenever a fraction is present gives ceil for either sign.
    inc_s       = {int_field_s[WI-1], int_field_s} + {{WI{1'b0}}, frac_nz_s};
  end

  // Detect overflow and select the combinational result.
  always_comb begin
    ceil_s = A;
    // The increment can leave the signed range only when the integer field
    // is the most positive integer. The two top bits of the widened sum then
    // disagree. A negative field never overflows because it only moves up.
    ovf_s  = frac_nz_s & (inc_s[WI] ^ inc_s[WI-1]);
    if (ovf_s) begin
      ceil_s = MAX_CODE;
    end else if (frac_nz_s) begin
      ceil_s = {inc_s[WI-1:0], {WF{1'b0}}};
    end else begin
      ceil_s = A;
    end
  end

  // Output stage: the valid bit follows in_valid, and the data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      ceil_r      <= {W{1'b0}};
      oflag_r     <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        ceil_r  <= ceil_s;
        oflag_r <= ovf_s;
      end else begin
        ceil_r  <= ceil_r;
        oflag_r <= oflag_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign ceilout   = ceil_r;
  assign oflag     = oflag_r;

endmodule

// File: tb/tb_fixed_ceil.sv
// ---------------------------------------------------------------------------
// tb_fixed_ceil
//
// Self-checking bench for fixed_ceil with WI=3 and WF=4. Expected values come
// from a real-valued ceil model, with saturation when the result is above
// 3.9375. Directed cases also carry their hand-derived constants.
// ---------------------------------------------------------------------------
module tb_fixed_ceil;

  localparam int WI = 3;
  localparam int WF = 4;
  localparam int W  = WI + WF;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] A;
  logic         out_valid;
  logic [W-1:0] ceilout;
  logic         oflag;

  int n_checks;
  int n_fail;

  logic [W-1:0] exp_c;
  logic         exp_o;

  fixed_ceil #(.WI(WI), .WF(WF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .out_valid (out_valid),
    .ceilout   (ceilout),
    .oflag     (oflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Real-valued model: ceil(a/16), saturated above the most positive code.
  task automatic model(input logic [W-1:0] a, output logic [W-1:0] c, output logic o);
    int  ai;
    real r;
    int  ci;
    ai = int'($signed(a));
    r  = $ceil(real'(ai) / 16.0);
    if (r > 63.0 / 16.0) begin
      c = 7'h3F;
      o = 1'b1;
    end else begin
      ci = int'(r);
      c  = 7'(ci * 16);
      o  = 1'b0;
    end
  endtask

  // Drive one cycle, then check all outputs shortly after the edge.
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] a);
    logic [W-1:0] mc;
    logic         mo;
    @(negedge clk);
    in_valid = v;
    A        = a;
    if (v) begin
      model(a, mc, mo);
      exp_c = mc;
      exp_o = mo;
    end
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_ceil"},  32'(ceilout),   32'(exp_c));
    check({tag, "_oflag"}, 32'(oflag),     32'(exp_o));
  endtask

  // Directed case: also compare against the hand-derived expected constants.
  task automatic directed(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] c, input logic o);
    cycle(tag, 1'b1, a);
    check({tag, "_const_ceil"},  32'(ceilout), 32'(c));
    check({tag, "_const_oflag"}, 32'(oflag),   32'(o));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_c    = '0;
    exp_o    = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = '0;

    // Reset state
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ceil",  32'(ceilout),   32'd0);
    check("rst_oflag", 32'(oflag),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Positive values
    directed("pos_0p5",   7'b000_1000, 7'b001_0000, 1'b0);
    directed("pos_1",     7'b001_0000, 7'b001_0000, 1'b0);
    directed("pos_2p81",  7'b010_1101, 7'b011_0000, 1'b0);
    // Negative values
    directed("neg_0p5",   7'b111_1000, 7'b000_0000, 1'b0);
    directed("neg_0p25",  7'b111_1100, 7'b000_0000, 1'b0);
    directed("neg_1p94",  7'b110_0001, 7'b111_0000, 1'b0);
    directed("neg_3p81",  7'b100_0011, 7'b101_0000, 1'b0);
    directed("neg_min",   7'b100_0000, 7'b100_0000, 1'b0);
    // Overflow boundary
    directed("ovf_3p75",  7'b011_1100, 7'b011_1111, 1'b1);
    directed("ovf_3p81",  7'b011_1101, 7'b011_1111, 1'b1);
    directed("nov_3",     7'b011_0000, 7'b011_0000, 1'b0);

    // Handshake 1,0,1,1; the gap holds the previous result
    cycle("hs0", 1'b1, 7'b000_0001);
    cycle("hs1", 1'b0, 7'b011_1111);
    check("hs1_hold", 32'(ceilout), 32'(7'b001_0000));
    cycle("hs2", 1'b1, 7'b011_1111);
    cycle("hs3", 1'b1, 7'b101_1000);

    // Asynchronous reset mid-stream while out_valid is high
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ceil",  32'(ceilout),   32'd0);
    check("arst_oflag", 32'(oflag),     32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    A        = 7'b011_1100;
    @(posedge clk);
    #1;
    check("arst_edge_valid", 32'(out_valid), 32'd0);
    check("arst_edge_ceil",  32'(ceilout),   32'd0);
    check("arst_edge_oflag", 32'(oflag),     32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    exp_c    = '0;
    exp_o    = 1'b0;
    directed("post_rst", 7'b000_0100, 7'b001_0000, 1'b0);

    // Exhaustive back-to-back sweep
    for (int i = 0; i < 128; i++) begin
      cycle("sweep", 1'b1, 7'(i));
    end

    // Random operands with random gaps
    for (int i = 0; i < 300; i++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), 7'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
